// File: rtl/hamming74_rx_deser.sv
// Serial receiver for framed Hamming(7,4) codewords: start 1, data LSB first, stop 0.
// Holds one codeword for a valid/ready consumer; flags bad stop bits and overruns.
module hamming74_rx_deser #(
  parameter int CW_WIDTH = 7,
  parameter int ERR_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rx_bit,
  input  logic                rx_en,
  output logic [CW_WIDTH-1:0] cw_data,
  output logic                cw_valid,
  input  logic                cw_ready,
  output logic                frame_err,
  output logic                overrun,
  output logic [ERR_W-1:0]    err_count
);
  // state  | meaning
  // IDLE   | line idle, waiting for a 1 start bit
  // DATA   | sampling codeword bit cnt
  // STOP   | expecting the 0 stop bit
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_STOP = 2'd2;

  localparam int CNT_W = (CW_WIDTH > 2) ? $clog2(CW_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CW_WIDTH - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  logic [1:0]          state;
  logic [CNT_W-1:0]    cnt;
  logic [CW_WIDTH-1:0] sreg;

  logic stop_smp, good_stop, bad_stop, xfer, load, drop;

  assign stop_smp  = rx_en && (state == S_STOP);
  assign good_stop = stop_smp && !rx_bit;
  assign bad_stop  = stop_smp && rx_bit;
  assign xfer      = cw_valid && cw_ready;
  // A buffer being drained this cycle can take the new codeword directly.
  assign load      = good_stop && (!cw_valid || cw_ready);
  assign drop      = good_stop && cw_valid && !cw_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      sreg  <= '0;
    end else if (rx_en) begin
      case (state)
        S_IDLE: begin
          if (rx_bit) begin
            state <= S_DATA;
            cnt   <= '0;
          end
        end
        S_DATA: begin
          sreg[cnt] <= rx_bit;
          if (cnt == CNT_LAST) state <= S_STOP;
          else                 cnt   <= cnt + CNT_W'(1);
        end
        S_STOP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cw_data   <= '0;
      cw_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      err_count <= '0;
    end else begin
      frame_err <= bad_stop;
      overrun   <= drop;
      if (load) begin
        cw_data  <= sreg;
        cw_valid <= 1'b1;
      end else if (xfer) begin
        cw_valid <= 1'b0;
      end
      if ((bad_stop || drop) && (err_count != ERR_MAX))
        err_count <= err_count + ERR_W'(1);
    end
  end
endmodule

// File: tb/tb_hamming74_rx_deser.sv
// Bench for hamming74_rx_deser: frame vectors from a table plus hand-written corner sequences,
// with delivered codewords checked against a scoreboard queue.
module tb_hamming74_rx_deser;
  localparam int ACC = 0;
  localparam int FE  = 1;
  localparam int OV  = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_bit;
  logic       rx_en;
  logic [6:0] cw_data;
  logic       cw_valid;
  logic       cw_ready;
  logic       frame_err;
  logic       overrun;
  logic [7:0] err_count;

  int checks = 0;
  int errors = 0;
  int exp_err = 0;
  logic [6:0] sb[$];

  typedef struct {
    logic [6:0] data;
    logic       stop;
    int         gap;
    logic       ready;
    int         outcome;
  } vec_t;
  vec_t vecs[6];

  hamming74_rx_deser #(.CW_WIDTH(7), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .rx_bit(rx_bit), .rx_en(rx_en),
    .cw_data(cw_data), .cw_valid(cw_valid), .cw_ready(cw_ready),
    .frame_err(frame_err), .overrun(overrun), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Codewords leave the buffer on a transfer; compare against the oldest expected one.
  always @(negedge clk) begin
    if (!rst && cw_valid && cw_ready) begin
      if (sb.size() == 0) check("unexpected_transfer", {25'd0, cw_data}, 32'hFFFF_FFFF);
      else check("delivered_cw", {25'd0, cw_data}, {25'd0, sb.pop_front()});
    end
  end

  task automatic send_bit(input logic b, input int gap, input logic raise_ready);
    repeat (gap) begin
      rx_en  = 1'b0;
      rx_bit = 1'($urandom);
      @(posedge clk); #1;
    end
    if (raise_ready) cw_ready = 1'b1;
    rx_en  = 1'b1;
    rx_bit = b;
    @(posedge clk); #1;
    rx_en  = 1'b0;
  endtask

  task automatic send_frame(input logic [6:0] d, input logic stop, input int gap,
                            input int outcome, input logic ready_at_stop);
    send_bit(1'b1, gap, 1'b0);
    for (int j = 0; j < 7; j++) send_bit(d[j], gap, 1'b0);
    check("pre_stop_valid", {31'd0, cw_valid}, {31'd0, sb.size() != 0});
    send_bit(stop, gap, ready_at_stop);
    if (outcome != ACC && exp_err < 255) exp_err++;
    check("frame_err", {31'd0, frame_err}, {31'd0, outcome == FE});
    check("overrun", {31'd0, overrun}, {31'd0, outcome == OV});
    check("err_count", {24'd0, err_count}, exp_err);
    if (outcome == ACC) begin
      check("acc_valid", {31'd0, cw_valid}, 32'd1);
      check("acc_data", {25'd0, cw_data}, {25'd0, d});
      sb.push_back(d);
    end else if (outcome == OV) begin
      check("ov_valid", {31'd0, cw_valid}, 32'd1);
      if (sb.size() != 0) check("ov_data_kept", {25'd0, cw_data}, {25'd0, sb[0]});
    end else begin
      check("fe_valid", {31'd0, cw_valid}, {31'd0, sb.size() != 0});
    end
  endtask

  initial begin
    rst = 1'b1; rx_bit = 1'b0; rx_en = 1'b0; cw_ready = 1'b1;
    vecs[0] = '{7'h55, 1'b0, 0, 1'b1, ACC};
    vecs[1] = '{7'h55, 1'b0, 2, 1'b1, ACC};
    vecs[2] = '{7'h2A, 1'b1, 0, 1'b1, FE};
    vecs[3] = '{7'h7F, 1'b0, 0, 1'b1, ACC};
    vecs[4] = '{7'h11, 1'b0, 1, 1'b0, ACC};
    vecs[5] = '{7'h22, 1'b0, 0, 1'b0, OV};

    repeat (3) @(posedge clk); #1;
    check("rst_data", {25'd0, cw_data}, 32'd0);
    check("rst_valid", {31'd0, cw_valid}, 32'd0);
    check("rst_pulses", {30'd0, frame_err, overrun}, 32'd0);
    check("rst_err_count", {24'd0, err_count}, 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      rx_en = 1'b0;
      @(posedge clk); #1;
      check("pulse_width", {30'd0, frame_err, overrun}, 32'd0);
      cw_ready = vecs[i].ready;
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].gap, vecs[i].outcome, 1'b0);
    end

    // Drain of 7'h11 and load of 7'h33 in the same cycle.
    send_frame(7'h33, 1'b0, 0, ACC, 1'b1);
    @(posedge clk); #1;
    check("pulse_width", {30'd0, frame_err, overrun}, 32'd0);

    // Start bit right after a stop bit, ready held high.
    send_frame(7'h01, 1'b0, 0, ACC, 1'b0);
    send_frame(7'h40, 1'b0, 0, ACC, 1'b0);

    // Async reset mid-frame with a codeword held and nonzero error count.
    rx_en = 1'b0;
    @(posedge clk); #1;
    cw_ready = 1'b0;
    send_frame(7'h5A, 1'b0, 0, ACC, 1'b0);
    send_bit(1'b1, 0, 1'b0);
    for (int j = 0; j < 4; j++) send_bit(1'b1, 0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("arst_data", {25'd0, cw_data}, 32'd0);
    check("arst_valid", {31'd0, cw_valid}, 32'd0);
    check("arst_pulses", {30'd0, frame_err, overrun}, 32'd0);
    check("arst_err_count", {24'd0, err_count}, 32'd0);
    sb.delete();
    exp_err = 0;
    @(negedge clk) rst = 1'b0;
    cw_ready = 1'b1;
    @(posedge clk); #1;
    send_frame(7'h0F, 1'b0, 0, ACC, 1'b0);

    // Error counter saturation.
    for (int k = 0; k < 260; k++) send_frame(7'h2A, 1'b1, 0, FE, 1'b0);
    repeat (3) @(posedge clk); #1;
    check("sat_hold", {24'd0, err_count}, 32'd255);
    check("sb_empty", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hamming74_rx_deser.md
# hamming74_rx_deser

Serial front end for the Hamming(7,4) decoder. It recovers framed 7-bit codewords from a single-bit input line, holds each one in a one-entry output buffer, and presents it to the downstream decoder over a valid/ready handshake. Framing errors and buffer overruns are flagged and counted so that line-level failures can be told apart from codeword bit errors.

## Interface
- `CW_WIDTH`, default 7: codeword bits per frame (≥2).
- `ERR_W`, default 8: error counter width.

- `clk` input 1: sole clock; all state changes on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `rx_bit` input 1: serial line data.
- `rx_en` input 1: bit strobe; `rx_bit` is sampled only on cycles with `rx_en`=1.
- `cw_data` output CW_WIDTH: received codeword; bit 0 is the first data bit received.
- `cw_valid` output 1: `cw_data` holds an undelivered codeword.
- `cw_ready` input 1: downstream accepts; transfer occurs when `cw_valid` and `cw_ready` are both 1 in the same cycle.
- `frame_err` output 1: one-cycle pulse, bad stop bit.
- `overrun` output 1: one-cycle pulse, completed frame dropped because the buffer was full.
- `err_count` output ERR_W: saturating count of `frame_err` and `overrun` events.

## Operation
- Frame format: start bit `1`, then CW_WIDTH data bits LSB first, then stop bit `0`. The idle line is `0`.
- The FSM has three states: IDLE, DATA and STOP. Only `rx_en` cycles advance it; cycles without `rx_en` hold all state.
- IDLE: if `rx_bit`=1, go to DATA and clear the bit counter to 0. If `rx_bit`=0, stay in IDLE.
- DATA: write `rx_bit` into shift register position `cnt`, then increment `cnt`. After the sample with `cnt`=CW_WIDTH-1, go to STOP.
- STOP, `rx_bit`=0 (good frame):
  - If the buffer is empty, or is being drained this same cycle, load the shift register into `cw_data` and set `cw_valid`.
  - Otherwise keep the old buffer contents, pulse `overrun`, and discard the new codeword.
  - Go to IDLE.
- STOP, `rx_bit`=1: pulse `frame_err`, discard the codeword, go to IDLE. This stop bit is not treated as a new start bit.
- Buffer:
  - `cw_valid` clears on transfer unless a load happens in the same cycle.
  - `cw_data` is stable whenever `cw_valid`=1 and no transfer occurs.
- `err_count`: increments by 1 per `frame_err` or `overrun` event. Both pulses cannot occur in the same cycle. It saturates at 2^ERR_W-1 and never wraps.
- Reset (asynchronous, any time, including mid-frame):
  - FSM to IDLE, `cnt`=0, shift register 0.
  - `cw_data`=0, `cw_valid`=0, `frame_err`=0, `overrun`=0, `err_count`=0.
  - A partial frame is discarded.

## Timing
- All outputs are registered.
- `cw_valid` rises the cycle after the stop-bit sample cycle, i.e. 1-cycle latency from the stop bit.
- The shortest frame is CW_WIDTH+2 `rx_en` cycles (9 by default). A start bit can be accepted on the `rx_en` cycle immediately after the stop bit.
- `frame_err` and `overrun` are high for exactly the one cycle after the stop-bit sample. `err_count` updates in that same cycle.
- Back-to-back frames with `cw_ready` tied to 1 never overrun.
- With `cw_ready`=0, the first frame is held and every further good frame pulses `overrun`.
- Simultaneous drain and load in one cycle: the new codeword replaces the old, `cw_valid` stays 1, and no overrun is flagged.
- `rx_en` gaps of any length inside a frame are legal and do not cause a timeout.

## Test plan
- Reset, then apply 1,1,0,1,0,1,0,1,0 with `rx_en`=1 every cycle and `cw_ready`=1 → `cw_data`=7'h55 and `cw_valid`=1 exactly one cycle after the stop bit, then transferred; `err_count`=0.
- Same frame, with `rx_en` high only every 3rd cycle → identical result 7'h55; no state advance on cycles with `rx_en`=0.
- Frame with data 7'h2A and stop bit 1 → `frame_err` high for one cycle, `cw_valid` stays 0, `err_count`=1. The following good frame 7'h7F is received correctly.
- `cw_ready`=0; send 7'h11, then 7'h22 → `cw_data` stays 7'h11, one `overrun` pulse, `err_count`=1. Raise `cw_ready` in the same cycle as the next stop bit (7'h33) → `cw_data`=7'h33, `cw_valid` stays 1, no overrun.
- Assert `rst` asynchronously after 4 data bits → all outputs 0 immediately. A full frame 7'h0F after deassertion is received correctly.
- Force 260 framing errors → `err_count` saturates at 255 and holds.
